// File: rtl/svc_rv_pkg.sv
// Shared definitions for the RV32 execute-stage blocks.
//   OP_*        : funct3[1:0] encoding of the M-extension divide/remainder ops
//   div_state_e : state encoding of the multi-cycle divider FSM
package svc_rv_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/svc_rv_div_mc.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU in the EX stage.
// One quotient bit per cycle, working on operand magnitudes, with a sign
// fix-up applied as the last iteration completes.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   EX holds a valid div/rem op (sampled only in IDLE)
//   op      in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_in  in   dividend (forwarded rs1)
//   rs2_in  in   divisor  (forwarded rs2)
//   flush   in   pipeline flush, aborts any op in progress
//   is_mc   out  op in progress (state != IDLE)
//   mc_rs1  out  dividend captured at start, fed back to EX forwarding
//   mc_rs2  out  divisor captured at start, fed back to EX forwarding
//   done    out  one-cycle pulse, result valid
//   result  out  quotient or remainder
module svc_rv_div_mc
  import svc_rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            flush,
  output logic            is_mc,
  output logic [XLEN-1:0] mc_rs1,
  output logic [XLEN-1:0] mc_rs2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  // Control state (reset)
  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mc_rs1_q, mc_rs1_d;
  logic [XLEN-1:0] mc_rs2_q, mc_rs2_d;
  logic [XLEN-1:0] result_q, result_d;

  // Datapath state (not reset; always loaded before use)
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;

  // Start-cycle decode of the incoming operands
  logic            in_signed, in_rem;
  logic [XLEN-1:0] a_abs, b_abs;

  assign in_signed = (op == OP_DIV) || (op == OP_REM);
  assign in_rem    = (op == OP_REM) || (op == OP_REMU);
  assign a_abs     = (in_signed && rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
  assign b_abs     = (in_signed && rs2_in[XLEN-1]) ? -rs2_in : rs2_in;

  // One shift-subtract iteration. The partial remainder is always below the
  // divisor, so bit XLEN of the trial difference is a reliable borrow flag.
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] step_rem, step_quo;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      step_rem = trial[XLEN-1:0];
      step_quo = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      step_rem = shifted[XLEN-1:0];
      step_quo = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up of the final iteration's outputs, selected as the result.
  logic [XLEN-1:0] fix_quo, fix_rem, fix_res;
  logic            op_is_rem;

  always_comb begin
    op_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    fix_quo   = qneg_q ? -step_quo : step_quo;
    fix_rem   = rneg_q ? -step_rem : step_rem;
    fix_res   = op_is_rem ? fix_rem : fix_quo;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mc_rs1_d = mc_rs1_q;
    mc_rs2_d = mc_rs2_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          mc_rs1_d = rs1_in;
          mc_rs2_d = rs2_in;
          op_d     = op;
          if (rs2_in == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend
            result_d = in_rem ? rs1_in : '1;
            state_d  = ST_DONE;
          end else if (in_signed && (rs1_in == SMIN) && (rs2_in == '1)) begin
            // Signed overflow: quotient is the dividend, remainder zero
            result_d = in_rem ? '0 : rs1_in;
            state_d  = ST_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            qneg_d  = in_signed && (rs1_in[XLEN-1] ^ rs2_in[XLEN-1]);
            rneg_d  = in_signed && rs1_in[XLEN-1];
            cnt_d   = CW'(XLEN);
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fix_res;
            state_d  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_DIV;
      cnt_q    <= '0;
      mc_rs1_q <= '0;
      mc_rs2_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mc_rs1_q <= mc_rs1_d;
      mc_rs2_q <= mc_rs2_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign is_mc  = (state_q != ST_IDLE);
  // A flush arriving in the DONE cycle cancels the writeback
  assign done   = (state_q == ST_DONE) && !flush;
  assign result = result_q;
  assign mc_rs1 = mc_rs1_q;
  assign mc_rs2 = mc_rs2_q;

endmodule

// File: tb/tb_svc_rv_div_mc.sv
// Directed testbench for svc_rv_div_mc (XLEN=32).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// Cycle N means the cycle following the N-th rising edge, counting the
// edge that samples start as edge 1.
module tb_svc_rv_div_mc;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] rs2_in;
  logic            flush;
  logic            is_mc;
  logic [XLEN-1:0] mc_rs1;
  logic [XLEN-1:0] mc_rs2;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  svc_rv_div_mc #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1_in (rs1_in),
    .rs2_in (rs2_in),
    .flush  (flush),
    .is_mc  (is_mc),
    .mc_rs1 (mc_rs1),
    .mc_rs2 (mc_rs2),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one op from the current cycle; expects done at cycle lat with exp.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    int cyc;
    int ismc_bad;
    start  = 1'b1;
    op     = o;
    rs1_in = a;
    rs2_in = b;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    ismc_bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (is_mc !== 1'b1) ismc_bad++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, expected %0d", name, cyc, lat);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got 0x%08h, expected 0x%08h", name, result, exp);
    end
    checks++;
    if (is_mc !== 1'b1 || ismc_bad != 0) begin
      errors++;
      $display("FAIL %s is_mc while busy: %0d low cycles, is_mc at done=%b, expected 0 and 1",
               name, ismc_bad, is_mc);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || is_mc !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: done=%b is_mc=%b, expected 0 0", name, done, is_mc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; op = 2'b00; rs1_in = '0; rs2_in = '0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if (is_mc !== 1'b0 || done !== 1'b0 || result !== '0 || mc_rs1 !== '0 || mc_rs2 !== '0) begin
      errors++;
      $display("FAIL reset state: is_mc=%b done=%b result=0x%08h mc_rs1=0x%08h mc_rs2=0x%08h, expected all 0",
               is_mc, done, result, mc_rs1, mc_rs2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    do_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
  endtask

  task automatic test_signed();
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
  endtask

  task automatic test_special();
    do_op(2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
    do_op(2'b10, 32'd5, 32'd0, 32'd5, 1, "rem_by_zero");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_overflow");
  endtask

  task automatic test_capture();
    int cyc;
    int bad;
    start  = 1'b1;
    op     = 2'b01;
    rs1_in = 32'h8408_0000;
    rs2_in = 32'h8408_0000;
    @(posedge clk); #1;
    start  = 1'b0;
    rs1_in = 32'hDEAD_BEEF;
    rs2_in = 32'd3;
    cyc    = 1;
    bad    = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (is_mc !== 1'b1 || mc_rs1 !== 32'h8408_0000 || mc_rs2 !== 32'h8408_0000) bad++;
      start = (cyc % 7 == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0 || cyc != 33) begin
      errors++;
      $display("FAIL capture hold: %0d bad cycles, done at %0d, expected 0 and 33", bad, cyc);
    end
    checks++;
    if (result !== 32'd1) begin
      errors++;
      $display("FAIL capture result: got 0x%08h, expected 0x00000001", result);
    end
    @(posedge clk); #1;
    checks++;
    if (mc_rs1 !== 32'h8408_0000 || mc_rs2 !== 32'h8408_0000 || is_mc !== 1'b0) begin
      errors++;
      $display("FAIL capture after done: mc_rs1=0x%08h mc_rs2=0x%08h is_mc=%b, expected 84080000 84080000 0",
               mc_rs1, mc_rs2, is_mc);
    end
  endtask

  task automatic test_flush();
    int dones;
    // flush together with start in IDLE: start ignored
    start = 1'b1; flush = 1'b1; op = 2'b01; rs1_in = 32'd50; rs2_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (is_mc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_with_start: is_mc=%b done=%b, expected 0 0", is_mc, done);
    end
    // flush during RUN at cycle 10
    start = 1'b1; rs1_in = 32'd1000; rs2_in = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (is_mc !== 1'b0) begin
      errors++;
      $display("FAIL flush_run is_mc: got %b, expected 0", is_mc);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || is_mc === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL flush_run activity: got %0d busy/done cycles, expected 0", dones);
    end
    do_op(2'b01, 32'd1000, 32'd10, 32'd100, 33, "divu_after_flush");
  endtask

  task automatic test_reset_mid_op();
    int act;
    start = 1'b1; op = 2'b00; rs1_in = 32'd77; rs2_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (is_mc !== 1'b0 || done !== 1'b0 || result !== '0 || mc_rs1 !== '0 || mc_rs2 !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: is_mc=%b done=%b result=0x%08h mc_rs1=0x%08h mc_rs2=0x%08h, expected all 0",
               is_mc, done, result, mc_rs1, mc_rs2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || is_mc === 1'b1) act++;
      @(posedge clk); #1;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_mid_op resume: got %0d busy/done cycles, expected 0", act);
    end
  endtask

  task automatic test_back_to_back();
    do_op(2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33, "b2b_divu");
    do_op(2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, "b2b_remu");
    do_op(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, "b2b_div_neg_neg");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_capture();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
